// File: rtl/keccak_lane_permuter.sv
// Streams in a 25-lane Keccak state, applies rho, pi, both or neither,
// and streams the 25 result lanes back out in index order.
//
// state   | meaning
// LOAD    | accept 25 input lanes into src_buf, mode taken from lane 0
// PERMUTE | 25 cycles, one src lane rotated/remapped into dst_buf per cycle
// DRAIN   | present dst_buf lanes 0..24 on the output handshake
module keccak_lane_permuter #(
    parameter int LANE_W = 64,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LANE_W-1:0] in_lane,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_lane,
    output logic [IDX_W-1:0]  out_idx,
    output logic [IDX_W-1:0]  cnt,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {LOAD, PERMUTE, DRAIN} state_t;

    // Mode 2'b11 (bypass) neither rotates nor remaps, so it needs no constant.
    localparam logic [1:0] MODE_PI     = 2'b00;
    localparam logic [1:0] MODE_RHO    = 2'b01;
    localparam logic [1:0] MODE_RHO_PI = 2'b10;

    state_t            state;
    logic [1:0]        mode_q;
    logic [2:0]        x_q;
    logic [2:0]        y_q;
    logic [LANE_W-1:0] src_buf [25];
    logic [LANE_W-1:0] dst_buf [25];

    logic [4:0]          idx;
    logic [4:0]          nxt_idx;
    logic                rot_en;
    logic                pi_en;
    logic [5:0]          shamt;
    logic [2*LANE_W-1:0] dbl;
    logic [LANE_W-1:0]   perm_lane;
    logic [4:0]          xy_sum;
    logic [2:0]          pi_row;
    logic [4:0]          dest;

    // Rho offsets indexed by lane number n = x + 5*y.
    function automatic logic [5:0] rho_off(input logic [4:0] n);
        case (n)
            5'd0:  rho_off = 6'd0;   5'd1:  rho_off = 6'd1;   5'd2:  rho_off = 6'd62;
            5'd3:  rho_off = 6'd28;  5'd4:  rho_off = 6'd27;  5'd5:  rho_off = 6'd36;
            5'd6:  rho_off = 6'd44;  5'd7:  rho_off = 6'd6;   5'd8:  rho_off = 6'd55;
            5'd9:  rho_off = 6'd20;  5'd10: rho_off = 6'd3;   5'd11: rho_off = 6'd10;
            5'd12: rho_off = 6'd43;  5'd13: rho_off = 6'd25;  5'd14: rho_off = 6'd39;
            5'd15: rho_off = 6'd41;  5'd16: rho_off = 6'd45;  5'd17: rho_off = 6'd15;
            5'd18: rho_off = 6'd21;  5'd19: rho_off = 6'd8;   5'd20: rho_off = 6'd18;
            5'd21: rho_off = 6'd2;   5'd22: rho_off = 6'd61;  5'd23: rho_off = 6'd56;
            5'd24: rho_off = 6'd14;  default: rho_off = 6'd0;
        endcase
    endfunction

    // Input never exceeds 2*4 + 3*4 = 20, so three conditional subtracts suffice.
    function automatic logic [2:0] mod5(input logic [4:0] a);
        logic [4:0] r;
        r = a;
        if (r >= 5'd10) r = r - 5'd10;
        if (r >= 5'd5)  r = r - 5'd5;
        if (r >= 5'd5)  r = r - 5'd5;
        mod5 = r[2:0];
    endfunction

    // Rotate the current source lane and compute its destination slot.
    always_comb begin
        idx       = cnt[4:0];
        nxt_idx   = idx + 5'd1;
        rot_en    = (mode_q == MODE_RHO) || (mode_q == MODE_RHO_PI);
        pi_en     = (mode_q == MODE_PI)  || (mode_q == MODE_RHO_PI);
        // LANE_W is a power of two, so the mod reduces to a mask.
        shamt     = rot_en ? (rho_off(idx) & 6'(LANE_W - 1)) : 6'd0;
        dbl       = {src_buf[idx], src_buf[idx]} << shamt;
        perm_lane = dbl[2*LANE_W-1 -: LANE_W];
        xy_sum    = {1'b0, x_q, 1'b0} + {2'b00, y_q} + {1'b0, y_q, 1'b0};
        pi_row    = mod5(xy_sum);
        dest      = pi_en ? ({2'b00, y_q} + {pi_row, 2'b00} + {2'b00, pi_row}) : idx;
    end

    // Lane storage carries no reset; every slot is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (state == LOAD && in_valid && in_ready) src_buf[idx] <= in_lane;
        if (state == PERMUTE)                      dst_buf[dest] <= perm_lane;
    end

    // Frame sequencing with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= LOAD;
            cnt       <= '0;
            x_q       <= 3'd0;
            y_q       <= 3'd0;
            mode_q    <= MODE_PI;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_lane  <= '0;
            out_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        if (idx == 5'd0) mode_q <= mode;
                        if (idx == 5'd24) begin
                            cnt      <= '0;
                            x_q      <= 3'd0;
                            y_q      <= 3'd0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            state    <= PERMUTE;
                        end else begin
                            cnt <= cnt + IDX_W'(1);
                        end
                    end
                end
                PERMUTE: begin
                    if (x_q == 3'd4) begin
                        x_q <= 3'd0;
                        y_q <= y_q + 3'd1;
                    end else begin
                        x_q <= x_q + 3'd1;
                    end
                    if (idx == 5'd24) begin
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        out_idx   <= '0;
                        // Slot 0 may be written on this very edge; forward it.
                        out_lane  <= (dest == 5'd0) ? perm_lane : dst_buf[0];
                        state     <= DRAIN;
                    end else begin
                        cnt <= cnt + IDX_W'(1);
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        if (idx == 5'd24) begin
                            out_valid <= 1'b0;
                            out_lane  <= '0;
                            out_idx   <= '0;
                            cnt       <= '0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= LOAD;
                        end else begin
                            cnt      <= cnt + IDX_W'(1);
                            out_idx  <= IDX_W'(nxt_idx);
                            out_lane <= dst_buf[nxt_idx];
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_lane_permuter.sv
// Directed bench for keccak_lane_permuter: a 64-bit instance for the main
// scenarios and an 8-bit instance for the narrow-lane rotation case.
module tb_keccak_lane_permuter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  mode;
    logic        in_valid, in_ready, out_valid, out_ready, busy, done;
    logic [63:0] in_lane, out_lane;
    logic [4:0]  out_idx, cnt;

    logic [1:0]  b_mode;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy, b_done;
    logic [7:0]  b_in_lane, b_out_lane;
    logic [4:0]  b_out_idx, b_cnt;

    keccak_lane_permuter #(.LANE_W(64), .IDX_W(5)) dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_lane(in_lane), .out_valid(out_valid), .out_ready(out_ready), .out_lane(out_lane),
        .out_idx(out_idx), .cnt(cnt), .busy(busy), .done(done)
    );

    keccak_lane_permuter #(.LANE_W(8), .IDX_W(5)) dut8 (
        .clk(clk), .rst(rst), .mode(b_mode), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_lane(b_in_lane), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_lane(b_out_lane),
        .out_idx(b_out_idx), .cnt(b_cnt), .busy(b_busy), .done(b_done)
    );

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;

    logic [63:0] tx [25];
    logic [63:0] rx [25];
    int   lat, loaded, got, order_bad, stab_bad;
    logic done_seen, done_after, valid_after;

    always @(negedge clk) if (done === 1'b1) done_pulses++;

    // Push tx[0..24] into the 64-bit instance; mode only valid on lane 0.
    task automatic load_frame(input logic [1:0] m);
        int i, t;
        i = 0; t = 0;
        while (i < 25 && t < 200) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_lane  = tx[i];
            mode     = (i == 0) ? m : ~m;
            if (in_ready === 1'b1) begin
                @(posedge clk);
                i++;
            end else t++;
        end
        loaded = i;
        #1;
        in_lane = '1;          // junk held valid while the block is busy
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
    endtask

    // Drain 25 beats into rx[], optionally toggling out_ready each cycle.
    task automatic collect_frame(input bit bp);
        int k, t;
        logic held;
        logic [63:0] h_lane;
        logic [4:0]  h_idx;
        k = 0; t = 0; held = 1'b0; order_bad = 0; stab_bad = 0;
        out_ready = 1'b1;
        while (k < 25 && t < 300) begin
            @(negedge clk);
            t++;
            if (held && (out_lane !== h_lane || out_idx !== h_idx || out_valid !== 1'b1)) stab_bad++;
            if (bp) out_ready = (t % 2 == 1);
            held = 1'b0;
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    if (out_idx !== 5'(k)) order_bad++;
                    rx[k] = out_lane;
                    k++;
                end else begin
                    held = 1'b1; h_lane = out_lane; h_idx = out_idx;
                end
            end
        end
        got = k;
        @(negedge clk);
        done_seen = done; valid_after = out_valid;
        @(negedge clk);
        done_after = done;
        out_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_lane = '0; mode = 2'b00; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_lane = '0; b_mode = 2'b00; b_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (out_lane !== 64'h0 || out_idx !== 5'd0) begin errors++; $display("FAIL reset_out_data got %h/%0d want 0/0", out_lane, out_idx); end
        checks++; if (cnt !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_status got cnt %0d busy %0b done %0b want 0 0 0", cnt, busy, done); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %0b want 1", in_ready); end
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready_w8 got %0b want 1", b_in_ready); end
    endtask

    task automatic test_pi();
        int p0, bad;
        p0 = done_pulses;
        for (int n = 0; n < 25; n++) tx[n] = 64'(n);
        load_frame(2'b00);
        checks++; if (loaded != 25) begin errors++; $display("FAIL pi_load got %0d beats want 25", loaded); end
        checks++; if (lat != 26) begin errors++; $display("FAIL pi_latency got %0d want 26", lat); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pi_busy_drain got %0b want 1", busy); end
        collect_frame(1'b0);
        checks++; if (got != 25 || order_bad != 0) begin errors++; $display("FAIL pi_beats got %0d beats %0d misordered want 25 0", got, order_bad); end
        checks++; if (rx[0] !== 64'd0) begin errors++; $display("FAIL pi_lane0 got %0d want 0", rx[0]); end
        checks++; if (rx[10] !== 64'd1) begin errors++; $display("FAIL pi_lane10 got %0d want 1", rx[10]); end
        checks++; if (rx[16] !== 64'd5) begin errors++; $display("FAIL pi_lane16 got %0d want 5", rx[16]); end
        checks++; if (rx[2] !== 64'd12) begin errors++; $display("FAIL pi_lane2 got %0d want 12", rx[2]); end
        checks++; if (rx[24] !== 64'd21) begin errors++; $display("FAIL pi_lane24 got %0d want 21", rx[24]); end
        bad = 0;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                if (rx[y + 5 * ((2 * x + 3 * y) % 5)] !== 64'(x + 5 * y)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL pi_full_frame got %0d wrong lanes want 0", bad); end
        checks++; if (done_seen !== 1'b1 || done_after !== 1'b0 || valid_after !== 1'b0) begin errors++; $display("FAIL pi_done got %0b,%0b valid %0b want 1,0 valid 0", done_seen, done_after, valid_after); end
        checks++; if (done_pulses - p0 != 1) begin errors++; $display("FAIL pi_done_count got %0d want 1", done_pulses - p0); end
    endtask

    task automatic test_rho();
        for (int n = 0; n < 25; n++) tx[n] = 64'd1;
        load_frame(2'b01);
        collect_frame(1'b0);
        checks++; if (rx[0] !== 64'h1) begin errors++; $display("FAIL rho_lane0 got %h want 1", rx[0]); end
        checks++; if (rx[1] !== 64'h2) begin errors++; $display("FAIL rho_lane1 got %h want 2", rx[1]); end
        checks++; if (rx[2] !== 64'h4000_0000_0000_0000) begin errors++; $display("FAIL rho_lane2 got %h want 4000000000000000", rx[2]); end
        checks++; if (rx[24] !== 64'h4000) begin errors++; $display("FAIL rho_lane24 got %h want 4000", rx[24]); end
    endtask

    task automatic test_rho_pi();
        int nz;
        for (int n = 0; n < 25; n++) tx[n] = 64'd0;
        tx[1] = 64'd1;
        load_frame(2'b10);
        collect_frame(1'b0);
        checks++; if (rx[10] !== 64'h2) begin errors++; $display("FAIL rhopi_lane10 got %h want 2", rx[10]); end
        nz = 0;
        for (int n = 0; n < 25; n++) if (n != 10 && rx[n] !== 64'd0) nz++;
        checks++; if (nz != 0) begin errors++; $display("FAIL rhopi_others got %0d nonzero want 0", nz); end
    endtask

    task automatic test_lane8();
        int i, t, k, nz;
        logic [7:0] r8 [25];
        i = 0; t = 0;
        while (i < 25 && t < 200) begin
            @(negedge clk);
            b_in_valid = 1'b1;
            b_in_lane  = (i == 2) ? 8'h01 : 8'h00;
            b_mode     = 2'b01;
            if (b_in_ready === 1'b1) begin
                @(posedge clk);
                i++;
            end else t++;
        end
        #1 b_in_valid = 1'b0;
        t = 0;
        while (b_out_valid !== 1'b1 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        b_out_ready = 1'b1;
        k = 0;
        while (k < 25 && t < 300) begin
            @(negedge clk);
            t++;
            if (b_out_valid === 1'b1) begin
                r8[k] = b_out_lane;
                k++;
            end
        end
        @(negedge clk);
        b_out_ready = 1'b0;
        checks++; if (k != 25) begin errors++; $display("FAIL w8_beats got %0d want 25", k); end
        checks++; if (r8[2] !== 8'h40) begin errors++; $display("FAIL w8_lane2 got %h want 40", r8[2]); end
        nz = 0;
        for (int n = 0; n < k; n++) if (n != 2 && r8[n] !== 8'h00) nz++;
        checks++; if (nz != 0) begin errors++; $display("FAIL w8_others got %0d nonzero want 0", nz); end
    endtask

    task automatic test_backpressure();
        int bad;
        for (int n = 0; n < 25; n++) tx[n] = 64'hA5A5_0000_0000_0000 | 64'(n * 3 + 7);
        load_frame(2'b11);
        checks++; if (lat != 26) begin errors++; $display("FAIL bp_latency got %0d want 26", lat); end
        collect_frame(1'b1);
        checks++; if (got != 25 || order_bad != 0) begin errors++; $display("FAIL bp_beats got %0d beats %0d misordered want 25 0", got, order_bad); end
        checks++; if (stab_bad != 0) begin errors++; $display("FAIL bp_stable got %0d unstable stalls want 0", stab_bad); end
        bad = 0;
        for (int n = 0; n < 25; n++) if (rx[n] !== tx[n]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_data got %0d wrong lanes want 0", bad); end
        checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL bp_done got %0b want 1", done_seen); end
    endtask

    task automatic test_reset_mid_frame();
        int p0, bad;
        for (int n = 0; n < 25; n++) tx[n] = 64'(n + 100);
        load_frame(2'b00);
        @(negedge clk);
        out_ready = 1'b1;
        repeat (7) @(posedge clk);
        #1 out_ready = 1'b0;
        checks++; if (cnt !== 5'd7 || out_idx !== 5'd7) begin errors++; $display("FAIL mid_cnt got %0d/%0d want 7/7", cnt, out_idx); end
        p0 = done_pulses;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || cnt !== 5'd0) begin errors++; $display("FAIL mid_abort got valid %0b cnt %0d want 0 0", out_valid, cnt); end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_abort_status got busy %0b in_ready %0b want 0 0", busy, in_ready); end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (done_pulses != p0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_done got %0d pulses valid %0b want 0 0", done_pulses - p0, out_valid); end
        for (int n = 0; n < 25; n++) tx[n] = {$urandom, $urandom};
        load_frame(2'b11);
        collect_frame(1'b0);
        checks++; if (got != 25 || order_bad != 0) begin errors++; $display("FAIL fresh_beats got %0d beats %0d misordered want 25 0", got, order_bad); end
        bad = 0;
        for (int n = 0; n < 25; n++) if (rx[n] !== tx[n]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL fresh_echo got %0d wrong lanes want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_pi();
        test_rho();
        test_rho_pi();
        test_lane8();
        test_backpressure();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
